nbit_dualread_regfile: RTL and testbench



---
 rtl/nbit_dualread_regfile_pkg.sv | 17 +
 rtl/nbit_dualread_regfile_if.sv | 14 +
 rtl/nbit_dualread_regfile_read_port.sv | 60 ++++++
 rtl/nbit_dualread_regfile.sv | 126 ++++++++++++
 tb/tb_nbit_dualread_regfile.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/nbit_dualread_regfile_pkg.sv
// Shared types and helpers for the dual-read register file.
// Optional hardwired-zero register 0 is selected with REGFILE_ZERO_REG_EN.
package regfile_pkg;

  localparam int C_BIT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // A register count of 1 or 2 still needs a one-bit address.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nbit_dualread_regfile_if.sv
// Read-port bundle: a request (addr/en) and its registered response (data/valid).
// Handshake: en sampled at edge N yields valid=1 with data throughout cycle N+1; there is no backpressure.
interface nbit_dualread_regfile_if #(
  parameter int AW = 3,
  parameter int W  = 32
);
  logic [AW-1:0] addr;
  logic          en;
  logic [W-1:0]  data;
  logic          valid;

  modport master (output addr, output en, input data, input valid);
  modport slave  (input addr, input en, output data, output valid);
endinterface

// File: rtl/nbit_dualread_regfile_read_port.sv
// One registered read port: range check, write-first forwarding, data/valid registers with hold.
// With REGFILE_ZERO_REG_EN defined, address 0 always reads as zero.
module regfile_read_port import regfile_pkg::*; #(
  parameter int P_RegCount = 8,
  parameter int P_BitWidth = C_BIT_WIDTH,
  parameter int AW         = addr_width(P_RegCount)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  nbit_dualread_regfile_if.slave rd,
  input  logic                  fwd_en_i,
  input  logic [AW-1:0]         fwd_addr_i,
  input  logic [P_BitWidth-1:0] fwd_data_i,
  input  logic [P_BitWidth-1:0] regs_i [P_RegCount]
);

  logic [P_BitWidth-1:0] data_q, data_d;
  logic                  valid_q;
  logic [P_BitWidth-1:0] word;
  logic [P_BitWidth-1:0] rd_val;
  logic                  in_range;

  assign in_range = int'(rd.addr) < P_RegCount;

  always_comb begin
    word = '0;
    for (int i = 0; i < P_RegCount; i++) begin
      if (rd.addr == AW'(i)) word = regs_i[i];
    end
  end

  // The forward path also carries the clear engine's zero, so the entry being cleared reads 0.
  always_comb begin
    rd_val = word;
    if (!in_range) begin
      rd_val = '0;
    end else if (fwd_en_i && (fwd_addr_i == rd.addr)) begin
      rd_val = fwd_data_i;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (rd.addr == '0) rd_val = '0;
`endif
  end

  assign data_d = rd.en ? rd_val : data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= rd.en;
    end
  end

  assign rd.data  = data_q;
  assign rd.valid = valid_q;

endmodule

// File: rtl/nbit_dualread_regfile.sv
// Register file with one write port, two registered read ports and a sequenced clear.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module nbit_dualread_regfile import regfile_pkg::*; #(
  parameter int  P_RegCount = 8,
  parameter int  P_BitWidth = C_BIT_WIDTH,
  localparam int AW         = addr_width(P_RegCount)
) (
  input  logic                  In_Clock,
  input  logic                  In_Reset_n,
  input  logic [AW-1:0]         In_WrAddr,
  input  logic [P_BitWidth-1:0] In_WrData,
  input  logic                  In_Write,
  input  logic [AW-1:0]         In_RdAddrA,
  input  logic                  In_ReadA,
  input  logic [AW-1:0]         In_RdAddrB,
  input  logic                  In_ReadB,
  input  logic                  In_Clear,
  output logic [P_BitWidth-1:0] Out_ReadDataA,
  output logic                  Out_ValidA,
  output logic [P_BitWidth-1:0] Out_ReadDataB,
  output logic                  Out_ValidB,
  output logic                  Out_Busy,
  output logic                  Out_WriteErr
);

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_idx_q, clr_idx_d;
  logic                  werr_q, werr_d;
  logic [P_BitWidth-1:0] regs_q [P_RegCount];

  logic                  wr_in_range, wr_zero, wr_acc;
  logic                  fwd_en;
  logic [AW-1:0]         fwd_addr;
  logic [P_BitWidth-1:0] fwd_data;

  assign wr_in_range = int'(In_WrAddr) < P_RegCount;
`ifdef REGFILE_ZERO_REG_EN
  assign wr_zero = (In_WrAddr == '0);
`else
  assign wr_zero = 1'b0;
`endif

  assign wr_acc = In_Write && (state_q == ST_IDLE) && wr_in_range && !wr_zero;
  assign werr_d = In_Write && ((state_q == ST_CLEAR) || !wr_in_range);

  // Single update path: either the accepted write or the clear engine's zero.
  assign fwd_en   = wr_acc || (state_q == ST_CLEAR);
  assign fwd_addr = (state_q == ST_CLEAR) ? clr_idx_q : In_WrAddr;
  assign fwd_data = (state_q == ST_CLEAR) ? '0 : In_WrData;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (In_Clear) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(P_RegCount - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge In_Clock) begin
    if (!In_Reset_n) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      werr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge In_Clock) begin
    if (!In_Reset_n) begin
      for (int i = 0; i < P_RegCount; i++) regs_q[i] <= '0;
    end else if (fwd_en) begin
      for (int i = 0; i < P_RegCount; i++) begin
        if (fwd_addr == AW'(i)) regs_q[i] <= fwd_data;
      end
    end
  end

  assign Out_Busy     = (state_q == ST_CLEAR);
  assign Out_WriteErr = werr_q;

  nbit_dualread_regfile_if #(.AW(AW), .W(P_BitWidth)) rd_a ();
  nbit_dualread_regfile_if #(.AW(AW), .W(P_BitWidth)) rd_b ();

  assign rd_a.addr     = In_RdAddrA;
  assign rd_a.en       = In_ReadA;
  assign Out_ReadDataA = rd_a.data;
  assign Out_ValidA    = rd_a.valid;
  assign rd_b.addr     = In_RdAddrB;
  assign rd_b.en       = In_ReadB;
  assign Out_ReadDataB = rd_b.data;
  assign Out_ValidB    = rd_b.valid;

  regfile_read_port #(.P_RegCount(P_RegCount), .P_BitWidth(P_BitWidth), .AW(AW)) u_rd_a (
    .clk_i      (In_Clock),
    .rst_ni     (In_Reset_n),
    .rd         (rd_a.slave),
    .fwd_en_i   (fwd_en),
    .fwd_addr_i (fwd_addr),
    .fwd_data_i (fwd_data),
    .regs_i     (regs_q)
  );

  regfile_read_port #(.P_RegCount(P_RegCount), .P_BitWidth(P_BitWidth), .AW(AW)) u_rd_b (
    .clk_i      (In_Clock),
    .rst_ni     (In_Reset_n),
    .rd         (rd_b.slave),
    .fwd_en_i   (fwd_en),
    .fwd_addr_i (fwd_addr),
    .fwd_data_i (fwd_data),
    .regs_i     (regs_q)
  );

endmodule

// File: tb/tb_nbit_dualread_regfile.sv
// Bench for nbit_dualread_regfile: an 8-entry and a 6-entry instance share one stimulus stream.
// Honours REGFILE_ZERO_REG_EN the same way the design does.
module tb_nbit_dualread_regfile;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr, ra_en, rb_en, clr;
  logic [2:0]  wa, ra, rb;
  logic [31:0] wd;

  nbit_dualread_regfile_if #(.AW(3), .W(32)) a8 ();
  nbit_dualread_regfile_if #(.AW(3), .W(32)) b8 ();
  nbit_dualread_regfile_if #(.AW(3), .W(32)) a6 ();
  nbit_dualread_regfile_if #(.AW(3), .W(32)) b6 ();

  assign a8.addr = ra;  assign a8.en = ra_en;
  assign a6.addr = ra;  assign a6.en = ra_en;
  assign b8.addr = rb;  assign b8.en = rb_en;
  assign b6.addr = rb;  assign b6.en = rb_en;

  logic [1:0]  busy, werr, va, vb;
  logic [31:0] da [2];
  logic [31:0] db [2];

  assign va[0] = a8.valid;  assign da[0] = a8.data;
  assign vb[0] = b8.valid;  assign db[0] = b8.data;
  assign va[1] = a6.valid;  assign da[1] = a6.data;
  assign vb[1] = b6.valid;  assign db[1] = b6.data;

  nbit_dualread_regfile #(.P_RegCount(8), .P_BitWidth(32)) dut8 (
    .In_Clock(clk), .In_Reset_n(rst_n),
    .In_WrAddr(wa), .In_WrData(wd), .In_Write(wr),
    .In_RdAddrA(a8.addr), .In_ReadA(a8.en), .In_RdAddrB(b8.addr), .In_ReadB(b8.en),
    .In_Clear(clr),
    .Out_ReadDataA(a8.data), .Out_ValidA(a8.valid),
    .Out_ReadDataB(b8.data), .Out_ValidB(b8.valid),
    .Out_Busy(busy[0]), .Out_WriteErr(werr[0])
  );

  nbit_dualread_regfile #(.P_RegCount(6), .P_BitWidth(32)) dut6 (
    .In_Clock(clk), .In_Reset_n(rst_n),
    .In_WrAddr(wa), .In_WrData(wd), .In_Write(wr),
    .In_RdAddrA(a6.addr), .In_ReadA(a6.en), .In_RdAddrB(b6.addr), .In_ReadB(b6.en),
    .In_Clear(clr),
    .Out_ReadDataA(a6.data), .Out_ValidA(a6.valid),
    .Out_ReadDataB(b6.data), .Out_ValidB(b6.valid),
    .Out_Busy(busy[1]), .Out_WriteErr(werr[1])
  );

  // reference model: register contents, clear progress, expected-response queues
  logic [31:0] mem [2][8];
  bit          m_busy [2];
  int          m_left [2];
  int          m_next [2];
  logic [31:0] last_a [2];
  logic [31:0] last_b [2];
  logic [3:0]  st_q   [2][$];
  logic [31:0] expa_q [2][$];
  logic [31:0] expb_q [2][$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int cnt(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] expect_read(input int k, input logic [2:0] a, input bit wr_ok);
    if (int'(a) >= cnt(k)) return 32'h0;
    if (ZERO_EN && a == 3'd0) return 32'h0;
    if (wr_ok && a == wa) return wd;
    if (m_busy[k] && int'(a) == m_next[k]) return 32'h0;
    return mem[k][a];
  endfunction

  always @(posedge clk) begin
    bit wr_ok, werr_e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 8; j++) mem[k][j] = 32'h0;
        m_busy[k] = 1'b0;
        m_left[k] = 0;
        m_next[k] = 0;
        last_a[k] = 32'h0;
        last_b[k] = 32'h0;
        st_q[k].push_back(4'b0000);
      end else begin
        wr_ok  = wr && !m_busy[k] && (int'(wa) < cnt(k)) && !(ZERO_EN && wa == 3'd0);
        werr_e = wr && (m_busy[k] || int'(wa) >= cnt(k));
        if (ra_en) expa_q[k].push_back(expect_read(k, ra, wr_ok));
        if (rb_en) expb_q[k].push_back(expect_read(k, rb, wr_ok));
        if (wr_ok) mem[k][wa] = wd;
        if (m_busy[k]) begin
          mem[k][m_next[k]] = 32'h0;
          m_next[k] = m_next[k] + 1;
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_busy[k] = 1'b0;
        end else if (clr) begin
          m_busy[k] = 1'b1;
          m_left[k] = cnt(k);
          m_next[k] = 0;
        end
        st_q[k].push_back({m_busy[k], werr_e, ra_en, rb_en});
      end
    end
  end

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [3:0]  s;
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      if (st_q[k].size() != 0) begin
        s = st_q[k].pop_front();
        chk($sformatf("dut%0d_busy", k),    32'(busy[k]), 32'(s[3]));
        chk($sformatf("dut%0d_werr", k),    32'(werr[k]), 32'(s[2]));
        chk($sformatf("dut%0d_valid_a", k), 32'(va[k]),   32'(s[1]));
        chk($sformatf("dut%0d_valid_b", k), 32'(vb[k]),   32'(s[0]));
        if (va[k]) begin
          if (expa_q[k].size() == 0) chk($sformatf("dut%0d_a_unexpected", k), 32'h1, 32'h0);
          else begin
            e = expa_q[k].pop_front();
            last_a[k] = e;
            chk($sformatf("dut%0d_a_data", k), da[k], e);
          end
        end else chk($sformatf("dut%0d_a_hold", k), da[k], last_a[k]);
        if (vb[k]) begin
          if (expb_q[k].size() == 0) chk($sformatf("dut%0d_b_unexpected", k), 32'h1, 32'h0);
          else begin
            e = expb_q[k].pop_front();
            last_b[k] = e;
            chk($sformatf("dut%0d_b_data", k), db[k], e);
          end
        end else chk($sformatf("dut%0d_b_hold", k), db[k], last_b[k]);
      end
    end
  end

  // driver
  task automatic step(input bit w, input logic [2:0] a, input logic [31:0] d,
                      input bit rea, input logic [2:0] aa, input bit reb, input logic [2:0] ab,
                      input bit c);
    wr = w; wa = a; wd = d;
    ra_en = rea; ra = aa; rb_en = reb; rb = ab;
    clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 32'h11 * (i + 1), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;

    // reset contents read back as zero on both ports
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 1'b1, 3'd5, 1'b0);
    idle();

    // write-first forwarding
    step(1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
    idle();

    // out-of-range write and reads (only the 6-entry instance rejects them)
    step(1'b1, 3'd7, 32'h1234, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0);
    idle();
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0);

    // sequenced clear with a rejected write during busy
    fill();
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 10; c++)
      step(c == 3, 3'd1, 32'hAAAA, 1'b1, 3'd7, 1'b1, 3'(c), c == 5);

    // reset in the middle of a clear, then a fresh full clear
    fill();
    step(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    idle();
    idle();
    rst_n = 1'b0;
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 3'(i), 1'b0, 3'd0, 1'b0);
    fill();
    step(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0);

    // register 0 behaviour
    step(1'b1, 3'd0, 32'h5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd0, 32'h9, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    idle();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 49) == 0));
    end
    rst_n = 1'b1;
    idle();
    idle();
    idle();
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
